// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the PLL supervisor / reconfiguration controller.
package pll_ctrl_pkg;

    localparam int ODIV_W = 7;
    localparam int CH_W   = 3;
    localparam int MAX_CH = 7;

    typedef enum logic [2:0] {
        RST_HOLD,
        WAIT_LOCK,
        LOCK_FILT,
        RUN,
        GATE,
        APPLY
    } state_t;

    // Extract one channel's divider from a packed divider vector (ch0 in the LSBs).
    function automatic logic [ODIV_W-1:0] odiv_field(input logic [MAX_CH*ODIV_W-1:0] vec,
                                                     input logic [CH_W-1:0]          ch);
        return vec[ch*ODIV_W +: ODIV_W];
    endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// LOCK synchroniser, consecutive-high qualification counter and two-cycle loss detector.
module pll_lock_filter
    import pll_ctrl_pkg::*;
#(
    parameter int LOCK_FILT_CYC = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_lock_i,
    input  logic i_count_en,
    output logic o_lock_s,
    output logic o_lock_good,
    output logic o_lock_lost
);

    localparam int             CW      = $clog2(LOCK_FILT_CYC + 1);
    localparam logic [CW-1:0]  GOOD_M1 = CW'(LOCK_FILT_CYC - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_low_prev;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_low_prev <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= pll_lock_i;
            r_sync2    <= r_sync1;
            r_low_prev <= ~r_sync2;
            // Count only while qualifying; any low sample restarts the run.
            if (i_count_en && r_sync2)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
        end
    end

    assign o_lock_s    = r_sync2;
    assign o_lock_good = i_count_en & r_sync2 & (r_cnt == GOOD_M1);
    assign o_lock_lost = ~r_sync2 & r_low_prev;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL reset sequencer, lock supervisor and per-channel ODIV reconfiguration controller.
module pll_reconfig_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int                      NUM_CH        = 7,
    parameter int                      RST_CYC       = 16,
    parameter int                      LOCK_FILT_CYC = 256,
    parameter int                      LOCK_TIMEOUT  = 65536,
    parameter int                      GATE_CYC      = 4,
    parameter int                      SETTLE_CYC    = 8,
    parameter logic [NUM_CH*ODIV_W-1:0] ODIV_INIT    = {{5{7'd8}}, 7'd50, 7'd3}
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pll_lock_i,
    output logic                       pll_reset_o,
    output logic [NUM_CH*ODIV_W-1:0]   odsel_o,
    output logic [NUM_CH-1:0]          enclk_o,
    output logic                       locked_o,
    input  logic                       cfg_valid_i,
    output logic                       cfg_ready_o,
    input  logic [CH_W-1:0]            cfg_ch_i,
    input  logic [ODIV_W-1:0]          cfg_odiv_i,
    output logic                       cfg_err_o,
    output logic [7:0]                 relock_cnt_o
);

    localparam int CNT_MAX_A = (RST_CYC > LOCK_TIMEOUT) ? RST_CYC : LOCK_TIMEOUT;
    localparam int CNT_MAX_B = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
    localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
    localparam int CNT_W     = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] RST_M1  = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GATE_M1 = CNT_W'(GATE_CYC - 1);
    localparam logic [CNT_W-1:0] SET_M1  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);

    state_t                     r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_pll_reset;
    logic [NUM_CH-1:0]          r_enclk;
    logic [NUM_CH*ODIV_W-1:0]   r_odsel;
    logic                       r_locked;
    logic                       r_ready;
    logic                       r_err;
    logic [7:0]                 r_relock;
    logic [CH_W-1:0]            r_ch;
    logic [ODIV_W-1:0]          r_odiv;

    logic                       w_lock_s;
    logic                       w_lock_good;
    logic                       w_lock_lost;
    logic                       w_lost_now;
    logic                       w_ch_bad;
    logic [7:0]                 w_relock_inc;
    logic [NUM_CH-1:0]          w_req_mask;
    logic [NUM_CH-1:0]          w_cur_mask;
    logic [NUM_CH*ODIV_W-1:0]   w_odsel_next;

    pll_lock_filter #(
        .LOCK_FILT_CYC(LOCK_FILT_CYC)
    ) u_lock_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_lock_i (pll_lock_i),
        .i_count_en (r_state == LOCK_FILT),
        .o_lock_s   (w_lock_s),
        .o_lock_good(w_lock_good),
        .o_lock_lost(w_lock_lost)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign w_req_mask[gi] = (cfg_ch_i == CH_W'(gi));
            assign w_cur_mask[gi] = (r_ch == CH_W'(gi));
            assign w_odsel_next[gi*ODIV_W +: ODIV_W] =
                w_cur_mask[gi] ? r_odiv : r_odsel[gi*ODIV_W +: ODIV_W];
        end
    endgenerate

    assign w_ch_bad     = ({1'b0, cfg_ch_i} >= NUM_CH_L);
    assign w_relock_inc = (r_relock == 8'hFF) ? r_relock : r_relock + 8'd1;
    assign w_lost_now   = w_lock_lost &&
                          (r_state == RUN || r_state == GATE || r_state == APPLY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RST_HOLD;
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            r_enclk     <= '0;
            r_odsel     <= ODIV_INIT;
            r_locked    <= 1'b0;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_relock    <= '0;
            r_ch        <= '0;
            r_odiv      <= '0;
        end else begin
            r_err <= 1'b0;
            if (w_lost_now) begin
                // A pending GATE request is simply dropped; odsel keeps whatever was loaded.
                r_state     <= RST_HOLD;
                r_cnt       <= '0;
                r_pll_reset <= 1'b1;
                r_enclk     <= '0;
                r_locked    <= 1'b0;
                r_ready     <= 1'b0;
                r_relock    <= w_relock_inc;
            end else begin
                case (r_state)
                    RST_HOLD: begin
                        if (r_cnt == RST_M1) begin
                            r_state     <= WAIT_LOCK;
                            r_cnt       <= '0;
                            r_pll_reset <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    WAIT_LOCK: begin
                        if (w_lock_s) begin
                            r_state <= LOCK_FILT;
                            r_cnt   <= '0;
                        end else if (r_cnt == TO_M1) begin
                            r_state     <= RST_HOLD;
                            r_cnt       <= '0;
                            r_pll_reset <= 1'b1;
                            r_relock    <= w_relock_inc;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    LOCK_FILT: begin
                        if (!w_lock_s) begin
                            r_state <= WAIT_LOCK;
                            r_cnt   <= '0;
                        end else if (w_lock_good) begin
                            r_state  <= RUN;
                            r_locked <= 1'b1;
                            r_enclk  <= '1;
                            r_ready  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (cfg_valid_i && r_ready) begin
                            r_ready <= 1'b0;
                            if (w_ch_bad) begin
                                r_err <= 1'b1;
                            end else begin
                                r_ch    <= cfg_ch_i;
                                r_odiv  <= cfg_odiv_i;
                                r_enclk <= r_enclk & ~w_req_mask;
                                r_state <= GATE;
                                r_cnt   <= '0;
                            end
                        end else begin
                            r_ready <= 1'b1;
                        end
                    end
                    GATE: begin
                        if (r_cnt == GATE_M1) begin
                            r_odsel <= w_odsel_next;
                            r_state <= APPLY;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    APPLY: begin
                        if (r_cnt == SET_M1) begin
                            r_state <= RUN;
                            r_enclk <= r_enclk | w_cur_mask;
                            r_ready <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= RST_HOLD;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign pll_reset_o  = r_pll_reset;
    assign odsel_o      = r_odsel;
    assign enclk_o      = r_enclk;
    assign locked_o     = r_locked;
    assign cfg_ready_o  = r_ready;
    assign cfg_err_o    = r_err;
    assign relock_cnt_o = r_relock;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Self-checking bench for pll_reconfig_ctrl: lock-up timing, divider requests, lock loss and relock retries.
module tb_pll_reconfig_ctrl;
    import pll_ctrl_pkg::*;

    localparam int NUM_CH        = 7;
    localparam int RST_CYC       = 4;
    localparam int LOCK_FILT_CYC = 8;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int GATE_CYC      = 2;
    localparam int SETTLE_CYC    = 3;
    localparam logic [48:0] INIT = {{5{7'd8}}, 7'd50, 7'd3};

    logic        clk;
    logic        rst_n;
    logic        pll_lock_i;
    logic        pll_reset_o;
    logic [48:0] odsel_o;
    logic [6:0]  enclk_o;
    logic        locked_o;
    logic        cfg_valid_i;
    logic        cfg_ready_o;
    logic [2:0]  cfg_ch_i;
    logic [6:0]  cfg_odiv_i;
    logic        cfg_err_o;
    logic [7:0]  relock_cnt_o;

    pll_reconfig_ctrl #(
        .NUM_CH(NUM_CH), .RST_CYC(RST_CYC), .LOCK_FILT_CYC(LOCK_FILT_CYC),
        .LOCK_TIMEOUT(LOCK_TIMEOUT), .GATE_CYC(GATE_CYC), .SETTLE_CYC(SETTLE_CYC),
        .ODIV_INIT(INIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_lock_i(pll_lock_i), .pll_reset_o(pll_reset_o),
        .odsel_o(odsel_o), .enclk_o(enclk_o), .locked_o(locked_o),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_ch_i(cfg_ch_i),
        .cfg_odiv_i(cfg_odiv_i), .cfg_err_o(cfg_err_o), .relock_cnt_o(relock_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ch;
        logic [6:0] odiv;
        logic       exp_err;
        logic [6:0] exp_field;
    } vec_t;

    int         n_checks;
    int         n_errors;
    int         exp_relock;
    logic [6:0] mdl [NUM_CH];
    vec_t       tbl [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [48:0] mdl_vec();
        logic [48:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i*7 +: 7] = mdl[i];
        return v;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pll_reset"}, pll_reset_o, 1);
        chk({tag, "_enclk"}, enclk_o, 0);
        chk({tag, "_odsel"}, odsel_o, INIT);
        chk({tag, "_locked"}, locked_o, 0);
        chk({tag, "_ready"}, cfg_ready_o, 0);
        chk({tag, "_err"}, cfg_err_o, 0);
        chk({tag, "_relock"}, relock_cnt_o, 0);
    endtask

    task automatic wait_locked(input logic lvl, input int budget, input string tag);
        int n;
        n = 0;
        while (locked_o !== lvl && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_wait_locked"}, locked_o, lvl);
    endtask

    task automatic count_reset_pulse(output int n);
        n = 0;
        while (pll_reset_o === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic do_req(input logic [2:0] ch, input logic [6:0] odiv, input logic exp_err,
                          input logic [6:0] exp_field, input string tag);
        int         n;
        int         low;
        bit         others_ok;
        logic [6:0] old;
        n = 0;
        while (cfg_ready_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_ready_wait"}, cfg_ready_o, 1);
        cfg_valid_i = 1'b1;
        cfg_ch_i    = ch;
        cfg_odiv_i  = odiv;
        tick();
        cfg_valid_i = 1'b0;
        if (exp_err) begin
            chk({tag, "_err"}, cfg_err_o, 1);
            chk({tag, "_ready_drop"}, cfg_ready_o, 0);
            chk({tag, "_odsel_kept"}, odsel_o, mdl_vec());
            tick();
            chk({tag, "_err_pulse"}, cfg_err_o, 0);
            chk({tag, "_ready_back"}, cfg_ready_o, 1);
            $display("txn %s ch=%0d odiv=%0d rejected", tag, ch, odiv);
        end else begin
            old = mdl[ch];
            chk({tag, "_no_err"}, cfg_err_o, 0);
            low = 0;
            others_ok = 1'b1;
            while (enclk_o[ch] === 1'b0 && low < 50) begin
                low++;
                if ((enclk_o | (7'h1 << ch)) !== 7'h7F) others_ok = 1'b0;
                if (low == GATE_CYC) chk({tag, "_odsel_before"}, odiv_field(odsel_o, ch), old);
                if (low == GATE_CYC + 1) chk({tag, "_odsel_after"}, odiv_field(odsel_o, ch), exp_field);
                tick();
            end
            chk({tag, "_gate_len"}, low, GATE_CYC + SETTLE_CYC);
            chk({tag, "_others_on"}, others_ok, 1);
            chk({tag, "_enclk_back"}, enclk_o, 7'h7F);
            chk({tag, "_ready_back"}, cfg_ready_o, 1);
            chk({tag, "_odsel_final"}, odsel_o & ~(49'h7F << (ch * 7)), mdl_vec() & ~(49'h7F << (ch * 7)));
            mdl[ch] = exp_field;
            $display("txn %s ch=%0d odiv=%0d %0d->%0d low=%0d", tag, ch, odiv, old, exp_field, low);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         rises;
        logic       prev;
        logic [2:0] rch;
        logic [6:0] rod;

        n_checks = 0;
        n_errors = 0;
        exp_relock = 0;
        for (int i = 0; i < NUM_CH; i++) mdl[i] = INIT[i*7 +: 7];

        tbl[0] = '{3'd1, 7'd25,  1'b0, 7'd25};
        tbl[1] = '{3'd7, 7'd9,   1'b1, 7'd0};
        tbl[2] = '{3'd0, 7'd0,   1'b0, 7'd0};
        tbl[3] = '{3'd6, 7'd127, 1'b0, 7'd127};
        tbl[4] = '{3'd3, 7'd8,   1'b0, 7'd8};
        tbl[5] = '{3'd2, 7'd1,   1'b0, 7'd1};

        rst_n = 1'b0;
        pll_lock_i = 1'b0;
        cfg_valid_i = 1'b0;
        cfg_ch_i = '0;
        cfg_odiv_i = '0;
        repeat (3) tick();
        check_reset_vals("reset");

        // Power-up: reset pulse length and lock qualification latency
        rst_n = 1'b1;
        count_reset_pulse(n);
        chk("rst_pulse_len", n, RST_CYC);
        repeat (10) tick();
        pll_lock_i = 1'b1;
        n = 0;
        while (locked_o !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("lock_latency", n, 2 + LOCK_FILT_CYC + 1);
        chk("run_enclk", enclk_o, 7'h7F);
        chk("run_ready", cfg_ready_o, 1);
        chk("run_relock", relock_cnt_o, 0);
        chk("run_pll_reset", pll_reset_o, 0);
        $display("txn powerup lock_latency=%0d", n);

        // Lock loss while ch0 is gated: the pending divider must be discarded
        pll_lock_i = 1'b0;
        tick();
        tick();
        chk("gloss_ready", cfg_ready_o, 1);
        cfg_valid_i = 1'b1;
        cfg_ch_i = 3'd0;
        cfg_odiv_i = 7'd4;
        tick();
        cfg_valid_i = 1'b0;
        pll_lock_i = 1'b1;
        chk("gloss_gate", enclk_o, 7'h7E);
        wait_locked(1'b0, 10, "gloss_drop");
        exp_relock++;
        chk("gloss_relock", relock_cnt_o, exp_relock);
        chk("gloss_enclk_off", enclk_o, 0);
        chk("gloss_ready_off", cfg_ready_o, 0);
        wait_locked(1'b1, 200, "gloss_relock");
        chk("gloss_odsel0", odiv_field(odsel_o, 3'd0), 7'd3);
        chk("gloss_enclk_on", enclk_o, 7'h7F);
        $display("txn gate_loss relock=%0d odsel0=%0d", relock_cnt_o, odiv_field(odsel_o, 3'd0));

        for (int i = 0; i < 6; i++)
            do_req(tbl[i].ch, tbl[i].odiv, tbl[i].exp_err, tbl[i].exp_field, $sformatf("tbl%0d", i));

        for (int i = 0; i < 24; i++) begin
            rch = 3'($urandom_range(0, 7));
            rod = 7'($urandom_range(0, 127));
            do_req(rch, rod, rch >= 3'(NUM_CH), rod, $sformatf("rnd%0d", i));
        end

        // Single-cycle dropout is ignored
        pll_lock_i = 1'b0;
        tick();
        pll_lock_i = 1'b1;
        repeat (6) tick();
        chk("glitch_locked", locked_o, 1);
        chk("glitch_relock", relock_cnt_o, exp_relock);
        chk("glitch_enclk", enclk_o, 7'h7F);
        $display("txn glitch locked=%0d", locked_o);

        // Three-cycle dropout forces a full relock
        pll_lock_i = 1'b0;
        repeat (3) tick();
        pll_lock_i = 1'b1;
        wait_locked(1'b0, 10, "loss");
        exp_relock++;
        chk("loss_relock", relock_cnt_o, exp_relock);
        chk("loss_enclk", enclk_o, 0);
        chk("loss_ready", cfg_ready_o, 0);
        count_reset_pulse(n);
        chk("loss_rst_pulse", n, RST_CYC);
        n = 0;
        while (locked_o !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("relock_latency", n, 1 + LOCK_FILT_CYC);
        chk("relock_odsel", odsel_o, mdl_vec());
        $display("txn loss relock=%0d latency=%0d", relock_cnt_o, n);

        // Asynchronous reset in the middle of APPLY
        n = 0;
        while (cfg_ready_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        cfg_valid_i = 1'b1;
        cfg_ch_i = 3'd2;
        cfg_odiv_i = 7'd20;
        tick();
        cfg_valid_i = 1'b0;
        repeat (2) tick();
        chk("apply_odsel2", odiv_field(odsel_o, 3'd2), 7'd20);
        chk("apply_enclk", enclk_o, 7'h7B);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        $display("txn async_reset odsel=%0h", odsel_o);

        // Lock never arrives: periodic retries and counter saturation
        pll_lock_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            n = 0;
            while (relock_cnt_o !== 8'(k) && n < 200) begin
                tick();
                n++;
            end
            chk($sformatf("retry%0d_period", k), n, RST_CYC + LOCK_TIMEOUT);
            chk($sformatf("retry%0d_pll_reset", k), pll_reset_o, 1);
            $display("txn retry relock=%0d period=%0d", relock_cnt_o, n);
        end
        n = 0;
        while (relock_cnt_o !== 8'd255 && n < 300 * (RST_CYC + LOCK_TIMEOUT)) begin
            tick();
            n++;
        end
        chk("relock_reach_255", relock_cnt_o, 255);
        rises = 0;
        prev = pll_reset_o;
        for (int i = 0; i < 3 * (RST_CYC + LOCK_TIMEOUT); i++) begin
            tick();
            if (pll_reset_o && !prev) rises++;
            prev = pll_reset_o;
        end
        chk("relock_saturated", relock_cnt_o, 255);
        chk("retry_pulses_after_sat", rises, 3);
        $display("txn saturation relock=%0d pulses=%0d", relock_cnt_o, rises);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
